// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: legacy core defines,
// stall-vector bit positions and encodings, and multi-cycle FSM state codes.
`ifndef PIPE_CTRL_DEFS_SVH
`define PIPE_CTRL_DEFS_SVH
`define RstEnable   1'b1
`define RegAddrBus  4:0
`define WriteEnable 1'b1
`define ReadEnable  1'b1
`endif

package pipe_ctrl_pkg;

  localparam int STALL_W   = 6;
  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM_BIT = 4;
  localparam int STALL_WB  = 5;

  // Each encoding holds every stage up to and including the requesting one
  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_LU   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_MC   = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

  localparam int MC_CNT_W = 16;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MC_BUSY = 1'b1
  } mc_state_e;

endpackage

// File: rtl/pipe_hazard_det.sv
// Combinational load-use hazard detector: an ID operand read that matches
// the destination of a load currently in EX.
module pipe_hazard_det (
  input  logic              id_reg1_rd_en_i,
  input  logic [`RegAddrBus] id_reg1_addr_i,
  input  logic              id_reg2_rd_en_i,
  input  logic [`RegAddrBus] id_reg2_addr_i,
  input  logic              ex_is_load_i,
  input  logic              ex_wr_en_i,
  input  logic [`RegAddrBus] ex_waddr_i,
  output logic              lu_o
);

  logic ex_load_wr;
  logic hit1;
  logic hit2;

  // r0 is hardwired to zero, so a load targeting it never creates a hazard
  assign ex_load_wr = ex_is_load_i && (ex_wr_en_i == `WriteEnable) && (ex_waddr_i != 5'd0);
  assign hit1 = (id_reg1_rd_en_i == `ReadEnable) && (id_reg1_addr_i == ex_waddr_i);
  assign hit2 = (id_reg2_rd_en_i == `ReadEnable) && (id_reg2_addr_i == ex_waddr_i);
  assign lu_o = ex_load_wr && (hit1 || hit2);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: prioritised stall vector, flush strobe, multi-cycle EX
// handshake with watchdog/cancel, and a saturating stall-cycle counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_reg1_rd_en,
  input  logic [4:0]        id_reg1_addr,
  input  logic              id_reg2_rd_en,
  input  logic [4:0]        id_reg2_addr,
  input  logic              ex_is_load,
  input  logic              ex_wr_en,
  input  logic [4:0]        ex_waddr,
  input  logic              ex_mc_req,
  input  logic              ex_mc_done,
  input  logic              mem_stall_req,
  input  logic              flush_req,
  input  logic              cnt_clr,
  output logic [5:0]        stall,
  output logic              flush,
  output logic              mc_cancel,
  output logic              mc_timeout,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [MC_CNT_W-1:0] WD_LAST = MC_CNT_W'(MC_TIMEOUT - 1);

  mc_state_e             state_q;
  logic [MC_CNT_W-1:0]   mc_cnt_q;
  logic                  mc_timeout_q;
  logic [CNT_W-1:0]      stall_cnt_q;
  logic [CNT_W-1:0]      stall_cnt_d;
  logic [STALL_W-1:0]    stall_sel;
  logic                  lu;
  logic                  busy;
  logic                  wd_fire;
  logic                  mcb;

  pipe_hazard_det u_hazard (
    .id_reg1_rd_en_i (id_reg1_rd_en),
    .id_reg1_addr_i  (id_reg1_addr),
    .id_reg2_rd_en_i (id_reg2_rd_en),
    .id_reg2_addr_i  (id_reg2_addr),
    .ex_is_load_i    (ex_is_load),
    .ex_wr_en_i      (ex_wr_en),
    .ex_waddr_i      (ex_waddr),
    .lu_o            (lu)
  );

  assign busy    = (state_q == ST_MC_BUSY);
  // A done arriving on the last allowed cycle wins over the watchdog
  assign wd_fire = busy && (mc_cnt_q == WD_LAST) && !ex_mc_done;
  assign mcb     = ex_mc_req && !ex_mc_done && !wd_fire;

  // Stall vector selection, highest-priority request first
  always_comb begin
    stall_sel = STALL_NONE;
    if (flush_req)          stall_sel = STALL_NONE;
    else if (mem_stall_req) stall_sel = STALL_MEM;
    else if (mcb)           stall_sel = STALL_MC;
    else if (lu)            stall_sel = STALL_LU;
  end

  // Combinational outputs are forced low while reset is held
  assign stall      = (rst == `RstEnable) ? STALL_NONE : stall_sel;
  assign flush      = (rst != `RstEnable) && flush_req;
  assign mc_cancel  = (rst != `RstEnable) && busy && (flush_req || wd_fire);
  assign mc_timeout = mc_timeout_q;
  assign stall_cnt  = stall_cnt_q;

  // Multi-cycle handshake FSM with busy-cycle counter and watchdog pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst == `RstEnable) begin
      state_q      <= ST_IDLE;
      mc_cnt_q     <= '0;
      mc_timeout_q <= 1'b0;
    end else begin
      mc_timeout_q <= wd_fire;
      case (state_q)
        ST_IDLE: begin
          if (ex_mc_req && !ex_mc_done && !flush_req) begin
            state_q  <= ST_MC_BUSY;
            mc_cnt_q <= MC_CNT_W'(1);
          end
        end
        ST_MC_BUSY: begin
          if (flush_req || ex_mc_done || !ex_mc_req || wd_fire) begin
            state_q  <= ST_IDLE;
            mc_cnt_q <= '0;
          end else begin
            mc_cnt_q <= mc_cnt_q + MC_CNT_W'(1);
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          mc_cnt_q <= '0;
        end
      endcase
    end
  end

  // Saturating stall-cycle counter next value; clear beats increment
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (cnt_clr)
      stall_cnt_d = '0;
    else if ((stall_sel != STALL_NONE) && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // Stall-cycle counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst == `RstEnable) stall_cnt_q <= '0;
    else                   stall_cnt_q <= stall_cnt_d;
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: two instances (default and short-watchdog/4-bit counter)
// share stimulus and are compared against a cycle-level behavioural model.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic id_reg1_rd_en, id_reg2_rd_en, ex_is_load, ex_wr_en;
  logic [4:0] id_reg1_addr, id_reg2_addr, ex_waddr;
  logic ex_mc_req, ex_mc_done, mem_stall_req, flush_req, cnt_clr;

  logic [5:0]  stall_a, stall_s;
  logic        flush_a, flush_s, canc_a, canc_s, tmo_a, tmo_s;
  logic [31:0] cnt_a;
  logic [3:0]  cnt_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.MC_TIMEOUT(64), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .id_reg1_rd_en(id_reg1_rd_en), .id_reg1_addr(id_reg1_addr),
    .id_reg2_rd_en(id_reg2_rd_en), .id_reg2_addr(id_reg2_addr),
    .ex_is_load(ex_is_load), .ex_wr_en(ex_wr_en), .ex_waddr(ex_waddr),
    .ex_mc_req(ex_mc_req), .ex_mc_done(ex_mc_done),
    .mem_stall_req(mem_stall_req), .flush_req(flush_req), .cnt_clr(cnt_clr),
    .stall(stall_a), .flush(flush_a), .mc_cancel(canc_a),
    .mc_timeout(tmo_a), .stall_cnt(cnt_a)
  );

  pipe_ctrl #(.MC_TIMEOUT(8), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst),
    .id_reg1_rd_en(id_reg1_rd_en), .id_reg1_addr(id_reg1_addr),
    .id_reg2_rd_en(id_reg2_rd_en), .id_reg2_addr(id_reg2_addr),
    .ex_is_load(ex_is_load), .ex_wr_en(ex_wr_en), .ex_waddr(ex_waddr),
    .ex_mc_req(ex_mc_req), .ex_mc_done(ex_mc_done),
    .mem_stall_req(mem_stall_req), .flush_req(flush_req), .cnt_clr(cnt_clr),
    .stall(stall_s), .flush(flush_s), .mc_cancel(canc_s),
    .mc_timeout(tmo_s), .stall_cnt(cnt_s)
  );

  // Reference model: per instance, whether an op is in flight and for how
  // many busy cycles, the pending timeout pulse and the stall-cycle tally.
  int     TO[2]   = '{64, 8};
  longint MAXC[2] = '{64'hFFFF_FFFF, 64'd15};
  bit     m_busy[2];
  int     m_run[2];
  bit     m_tmo[2];
  longint m_cnt[2];

  typedef struct {
    bit r1e; logic [4:0] r1a; bit r2e; logic [4:0] r2a;
    bit ld;  bit we; logic [4:0] wa; bit mem; bit fl;
    logic [5:0] st; bit fo;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_lu();
    return ex_is_load && ex_wr_en && (ex_waddr != 0) &&
           ((id_reg1_rd_en && id_reg1_addr == ex_waddr) ||
            (id_reg2_rd_en && id_reg2_addr == ex_waddr));
  endfunction

  function automatic bit m_wd(int i);
    return m_busy[i] && (m_run[i] == TO[i] - 1) && !ex_mc_done;
  endfunction

  function automatic logic [5:0] m_stall(int i);
    if (flush_req)                                return 6'b000000;
    if (mem_stall_req)                            return 6'b011111;
    if (ex_mc_req && !ex_mc_done && !m_wd(i))     return 6'b001111;
    if (m_lu())                                   return 6'b000111;
    return 6'b000000;
  endfunction

  function automatic bit m_cancel(int i);
    return m_busy[i] && (flush_req || m_wd(i));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0; m_run[i] = 0; m_tmo[i] = 0; m_cnt[i] = 0;
    end
  endtask

  task automatic idle_in();
    id_reg1_rd_en = 0; id_reg1_addr = 0; id_reg2_rd_en = 0; id_reg2_addr = 0;
    ex_is_load = 0; ex_wr_en = 0; ex_waddr = 0; ex_mc_req = 0; ex_mc_done = 0;
    mem_stall_req = 0; flush_req = 0; cnt_clr = 0;
  endtask

  // Wait for the falling edge and compare both instances with the model
  task automatic sample();
    @(negedge clk);
    chk("stall_a", stall_a, m_stall(0));
    chk("stall_s", stall_s, m_stall(1));
    chk("flush_a", flush_a, flush_req);
    chk("flush_s", flush_s, flush_req);
    chk("cancel_a", canc_a, m_cancel(0));
    chk("cancel_s", canc_s, m_cancel(1));
    chk("tmo_a", tmo_a, m_tmo[0]);
    chk("tmo_s", tmo_s, m_tmo[1]);
    chk("cnt_a", cnt_a, m_cnt[0]);
    chk("cnt_s", cnt_s, m_cnt[1]);
  endtask

  // Advance the model across the rising edge, then release the inputs slot
  task automatic adv();
    bit wd[2];
    logic [5:0] st[2];
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      wd[i] = m_wd(i);
      st[i] = m_stall(i);
    end
    for (int i = 0; i < 2; i++) begin
      if (cnt_clr) m_cnt[i] = 0;
      else if (st[i] != 0 && m_cnt[i] < MAXC[i]) m_cnt[i]++;
      m_tmo[i] = wd[i];
      if (!m_busy[i]) begin
        m_busy[i] = ex_mc_req && !ex_mc_done && !flush_req;
        m_run[i]  = m_busy[i] ? 1 : 0;
      end else if (flush_req || ex_mc_done || !ex_mc_req || wd[i]) begin
        m_busy[i] = 0; m_run[i] = 0;
      end else begin
        m_run[i]++;
      end
    end
    #1;
  endtask

  task automatic clr_cycle();
    idle_in(); cnt_clr = 1; sample(); adv(); cnt_clr = 0;
  endtask

  initial begin
    vecs[0] = '{1, 5'd3, 0, 5'd0, 1, 1, 5'd3, 0, 0, 6'b000111, 0};
    vecs[1] = '{1, 5'd0, 0, 5'd0, 1, 1, 5'd0, 0, 0, 6'b000000, 0};
    vecs[2] = '{0, 5'd1, 1, 5'd7, 1, 1, 5'd7, 0, 0, 6'b000111, 0};
    vecs[3] = '{0, 5'd3, 0, 5'd3, 1, 1, 5'd3, 0, 0, 6'b000000, 0};
    vecs[4] = '{1, 5'd3, 0, 5'd0, 0, 1, 5'd3, 0, 0, 6'b000000, 0};
    vecs[5] = '{1, 5'd3, 0, 5'd0, 1, 0, 5'd3, 0, 0, 6'b000000, 0};
    vecs[6] = '{1, 5'd9, 0, 5'd0, 1, 1, 5'd9, 1, 0, 6'b011111, 0};
    vecs[7] = '{1, 5'd9, 0, 5'd0, 1, 1, 5'd9, 0, 1, 6'b000000, 1};
    vecs[8] = '{0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 1, 1, 6'b000000, 1};
    vecs[9] = '{1, 5'd4, 1, 5'd5, 1, 1, 5'd6, 0, 0, 6'b000000, 0};

    // Reset held: combinational outputs must be low even with requests up
    idle_in(); rst = 1; mem_stall_req = 1; flush_req = 1;
    model_reset();
    #2;
    chk("rst_stall", stall_a, 0);
    chk("rst_flush", flush_a, 0);
    chk("rst_cnt", cnt_a, 0);
    idle_in();
    #11 rst = 0;
    @(posedge clk); #1;

    // Load-use gives one stall cycle and one count
    clr_cycle();
    id_reg1_rd_en = 1; id_reg1_addr = 5'd3; ex_is_load = 1; ex_wr_en = 1; ex_waddr = 5'd3;
    sample(); chk("lu_stall", stall_a, 6'b000111); adv();
    idle_in(); sample(); chk("lu_cnt", cnt_a, 1); adv();

    // Single-cycle combinational vectors from IDLE
    for (int v = 0; v < 10; v++) begin
      idle_in();
      id_reg1_rd_en = vecs[v].r1e; id_reg1_addr = vecs[v].r1a;
      id_reg2_rd_en = vecs[v].r2e; id_reg2_addr = vecs[v].r2a;
      ex_is_load = vecs[v].ld; ex_wr_en = vecs[v].we; ex_waddr = vecs[v].wa;
      mem_stall_req = vecs[v].mem; flush_req = vecs[v].fl;
      sample();
      chk($sformatf("vec%0d_stall", v), stall_a, vecs[v].st);
      chk($sformatf("vec%0d_flush", v), flush_a, vecs[v].fo);
      adv();
    end

    // Divide: 32 stall cycles, released on the done cycle
    clr_cycle();
    ex_mc_req = 1;
    for (int k = 1; k <= 32; k++) begin
      sample(); chk($sformatf("div_stall%0d", k), stall_a, 6'b001111); adv();
    end
    ex_mc_done = 1;
    sample(); chk("div_done_stall", stall_a, 0); adv();
    idle_in(); sample(); chk("div_cnt", cnt_a, 32); adv();

    // Watchdog on the short instance
    clr_cycle();
    ex_mc_req = 1;
    for (int k = 1; k <= 9; k++) begin
      sample();
      chk($sformatf("wd_cancel%0d", k), canc_s, (k == 8) ? 1 : 0);
      chk($sformatf("wd_tmo%0d", k), tmo_s, (k == 9) ? 1 : 0);
      if (k == 8) chk("wd_stall", stall_s, 0);
      adv();
    end
    idle_in(); sample(); adv();

    // Flush on busy cycle 5
    ex_mc_req = 1;
    for (int k = 1; k <= 6; k++) begin
      if (k == 6) flush_req = 1;
      sample();
      if (k == 6) begin
        chk("fl_flush", flush_a, 1);
        chk("fl_cancel", canc_a, 1);
        chk("fl_stall", stall_a, 0);
      end
      adv();
    end
    idle_in(); sample(); chk("fl_after_cancel", canc_a, 0); adv();

    // Priority: MEM over multi-cycle over load-use
    id_reg2_rd_en = 1; id_reg2_addr = 5'd12; ex_is_load = 1; ex_wr_en = 1; ex_waddr = 5'd12;
    ex_mc_req = 1; mem_stall_req = 1;
    for (int k = 0; k < 3; k++) begin
      sample(); chk("pri_mem", stall_a, 6'b011111); adv();
    end
    mem_stall_req = 0;
    for (int k = 0; k < 2; k++) begin
      sample(); chk("pri_mc", stall_a, 6'b001111); adv();
    end
    ex_mc_done = 1;
    sample(); chk("pri_lu", stall_a, 6'b000111); adv();
    idle_in(); sample(); adv();

    // Counter saturation on the 4-bit instance and clear priority
    clr_cycle();
    mem_stall_req = 1;
    for (int k = 0; k < 20; k++) begin sample(); adv(); end
    cnt_clr = 1;
    sample(); chk("sat_cnt_s", cnt_s, 15); chk("sat_cnt_a", cnt_a, 20); adv();
    cnt_clr = 0; mem_stall_req = 0;
    sample(); chk("clr_cnt_s", cnt_s, 0); chk("clr_cnt_a", cnt_a, 0); adv();

    // Asynchronous reset in the middle of a busy period
    ex_mc_req = 1;
    for (int k = 0; k < 4; k++) begin sample(); adv(); end
    #2 rst = 1; flush_req = 1;
    #1;
    chk("arst_stall", stall_a, 0);
    chk("arst_flush", flush_a, 0);
    chk("arst_cancel", canc_a, 0);
    chk("arst_cnt", cnt_a, 0);
    chk("arst_tmo_s", tmo_s, 0);
    model_reset();
    @(posedge clk); #1;
    flush_req = 0; rst = 0;
    sample(); chk("arst_reenter", stall_a, 6'b001111); adv();
    idle_in(); sample(); adv();

    // Randomised traffic against the model
    for (int n = 0; n < 600; n++) begin
      id_reg1_rd_en = 1'($urandom_range(0, 1));
      id_reg2_rd_en = 1'($urandom_range(0, 1));
      id_reg1_addr  = 5'($urandom_range(0, 3));
      id_reg2_addr  = 5'($urandom_range(0, 3));
      ex_waddr      = 5'($urandom_range(0, 3));
      ex_is_load    = 1'($urandom_range(0, 1));
      ex_wr_en      = 1'($urandom_range(0, 3) != 0);
      mem_stall_req = ($urandom_range(0, 7) == 0);
      flush_req     = ($urandom_range(0, 19) == 0);
      cnt_clr       = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 11) == 0) ex_mc_req = ~ex_mc_req;
      ex_mc_done    = ex_mc_req && ($urandom_range(0, 13) == 0);
      sample(); adv();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
